day1_line_parser: RTL
=====================

# day1_line_parser

Upstream front end for the day-1 calorie tracker: consumes the puzzle input as a byte stream of ASCII text with a valid/ready handshake, converts each decimal line to a 16-bit binary value, and presents it on `par_input` with a one-cycle `next_val` strobe. A blank line is emitted as value 0, the elf separator the tracker expects. It also reports line count, completion and sticky error flags.

## Interface
- No parameters; all widths are fixed: 8-bit bytes, 16-bit values.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_byte` in 8: ASCII character.
- `in_valid` in 1: `in_byte` is valid.
- `in_last` in 1: qualifies `in_byte` as the final byte of the file.
- `in_ready` out 1: the parser accepts a byte this cycle.
- `par_input` out 16: parsed value; held stable between strobes.
- `next_val` out 1: registered one-cycle strobe; `par_input` is valid and stable across its rising edge.
- `line_count` out 16: number of values emitted, including separators; wraps.
- `done` out 1: sticky; set after the `in_last` byte has been fully processed.
- `err_overflow` out 1: sticky; a line exceeded 65535.
- `err_char` out 1: sticky; an illegal character was seen, or a line evaluated to value 0.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- `in_ready = (state == ACCUM) && !done`, combinational from registered state.
- States:
  - ACCUM: accepts bytes.
  - SETUP: `par_input` is loaded; `next_val` is 0.
  - STROBE: `next_val` is 1.
  - ACCUM is re-entered after STROBE.
- Accepted byte handling in ACCUM:
  - '0'..'9' (0x30..0x39): `acc = acc*10 + d`, computed as `(acc<<3) + (acc<<1) + d` in 20 bits. If the result exceeds 0xFFFF, `acc` saturates at 0xFFFF and `err_overflow` is set. `have_digit` is set.
  - 0x0A: load `par_input` with `acc` if `have_digit`, else 0. Clear `acc` and `have_digit`, then go to SETUP.
  - 0x0D: ignored.
  - Any other byte: ignored; sets `err_char`.
- A line with digits that evaluates to 0 is emitted as 0 and sets `err_char`, because 0 is ambiguous with the separator.
- `in_last` is honoured on any accepted byte, after that byte's normal processing:
  - If a value is pending (`have_digit` set and the byte is not 0x0A), it is emitted through SETUP/STROBE.
  - `done` sets on the edge that leaves STROBE, or on the accept edge itself if nothing is emitted.
  - After `done`, all input is refused until reset.
- Every emission passes through SETUP then STROBE, and increments `line_count` on entry to STROBE.

## Timing
- Reset values: `par_input` = 0, `next_val` = 0, `line_count` = 0, `done` = 0, all error flags = 0. State is ACCUM, `acc` = 0, `have_digit` = 0. `in_ready` is 1 after reset.
- Digit, CR and illegal bytes each take 1 cycle; back-to-back acceptance is allowed.
- Emission sequence for a newline accepted at edge E0:
  - E0: `par_input` updates.
  - E1: `next_val` rises.
  - E2: `next_val` falls and `in_ready` returns high.
  - `in_ready` is low for exactly 2 cycles.
  - `par_input` is stable 1 cycle before and at least 1 cycle after the `next_val` rise.
- Minimum strobe spacing is 3 cycles. `next_val` is never high for two consecutive cycles.
- Reset mid-operation: asynchronous clear of everything, including any in-progress SETUP/STROBE. `next_val` drops immediately; the partial line is discarded.
- `in_valid` with `in_ready` low: the byte is not consumed, and the source must hold it.

## Structure
- Package `day1_pkg`:
  - ASCII constants `ASCII_0`, `ASCII_9`, `ASCII_LF`, `ASCII_CR`.
  - State encoding localparams ACCUM/SETUP/STROBE.
  - `VAL_W = 16`.
- One sub-module, `day1_digit_acc`: combinational times-10-plus-digit with saturation. Inputs `acc`, `d`; outputs `next_acc`, `ovf`.
- The FSM, the output registers and the flags live in `day1_line_parser`.

## Test plan
- "1000\n2000\n\n4000\n" with `in_last` on the final LF:
  - Strobes carry 1000, 2000, 0, 4000.
  - `line_count` = 4; `done` = 1; no errors.
  - `next_val` is high exactly 4 cycles, each preceded by one stable `par_input` cycle.
- "70000\n":
  - `par_input` = 65535 at the strobe; `err_overflow` = 1.
  - The next line "5\n" yields 5, so `acc` was cleared.
- "12\r\n3a4\n":
  - Strobes carry 12 then 34.
  - `err_char` = 1 from 'a'; CR is silently ignored.
- `in_valid` held high continuously over "1\n2\n":
  - `in_ready` shows the 1-1-0-0 pattern per line.
  - No byte is dropped or duplicated; strobes carry 1 and 2.
- "99" with `in_last` on the second '9' and no LF:
  - 99 is emitted; `done` rises on the edge leaving STROBE.
  - Further bytes are refused (`in_ready` = 0).
- `rst_n` asserted during STROBE of "500\n":
  - `next_val` drops asynchronously and all outputs are 0.
  - After release, "7\n" yields 7 with `line_count` = 1.

Source files
------------

// File: rtl/day1_pkg.sv
// Shared constants and state encoding for the day-1 line parser.
package day1_pkg;

   localparam int unsigned VAL_W = 16;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_e;

endpackage

// File: rtl/day1_digit_acc.sv
// Combinational acc*10 + d with saturation at the value width.
module day1_digit_acc
   import day1_pkg::*;
(
   input  logic [VAL_W-1:0] acc,
   input  logic [3:0]       d,
   output logic [VAL_W-1:0] next_acc,
   output logic             ovf
);

   logic [19:0] wide_acc;
   logic [19:0] sum;

   assign wide_acc = {4'b0, acc};
   // 65535*10 + 9 still fits in 20 bits, so the sum itself never wraps.
   assign sum      = (wide_acc << 3) + (wide_acc << 1) + {16'b0, d};
   assign ovf      = (sum > 20'h0FFFF);
   assign next_acc = ovf ? {VAL_W{1'b1}} : sum[VAL_W-1:0];

endmodule

// File: rtl/day1_line_parser.sv
// Byte-stream decimal line parser: one value per line, blank line emitted as 0.
module day1_line_parser
   import day1_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [VAL_W-1:0] par_input,
   output logic             next_val,
   output logic [15:0]      line_count,
   output logic             done,
   output logic             err_overflow,
   output logic             err_char
);

   state_e           state_q, state_d;
   logic [VAL_W-1:0] acc_q, acc_d;
   logic             have_digit_q, have_digit_d;
   logic [VAL_W-1:0] par_q, par_d;
   logic             next_val_q, next_val_d;
   logic [15:0]      line_count_q, line_count_d;
   logic             done_q, done_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_char_q, err_char_d;
   logic             last_pend_q, last_pend_d;

   logic             accept;
   logic             is_digit;
   logic [VAL_W-1:0] dig_next;
   logic             dig_ovf;
   logic [VAL_W-1:0] acc_post;
   logic             hd_post;
   logic             emit;

   assign in_ready = (state_q == ACCUM) && !done_q;
   assign accept   = in_valid && in_ready;
   assign is_digit = (in_byte >= ASCII_0) && (in_byte <= ASCII_9);

   day1_digit_acc u_digit_acc (
      .acc      (acc_q),
      .d        (in_byte[3:0]),
      .next_acc (dig_next),
      .ovf      (dig_ovf)
   );

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      have_digit_d = have_digit_q;
      par_d        = par_q;
      next_val_d   = 1'b0;
      line_count_d = line_count_q;
      done_d       = done_q;
      err_ovf_d    = err_ovf_q;
      err_char_d   = err_char_q;
      last_pend_d  = last_pend_q;
      acc_post     = acc_q;
      hd_post      = have_digit_q;
      emit         = 1'b0;

      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               if (is_digit) begin
                  acc_post = dig_next;
                  hd_post  = 1'b1;
                  if (dig_ovf) err_ovf_d = 1'b1;
               end else if ((in_byte != ASCII_LF) && (in_byte != ASCII_CR)) begin
                  err_char_d = 1'b1;
               end
               // in_last flushes a pending value even without a trailing LF.
               emit         = (in_byte == ASCII_LF) || (in_last && hd_post);
               acc_d        = acc_post;
               have_digit_d = hd_post;
               if (emit) begin
                  // acc_post is 0 whenever no digit was seen, giving the separator.
                  par_d        = acc_post;
                  if (hd_post && (acc_post == '0)) err_char_d = 1'b1;
                  acc_d        = '0;
                  have_digit_d = 1'b0;
                  last_pend_d  = in_last;
                  state_d      = SETUP;
               end else if (in_last) begin
                  done_d = 1'b1;
               end
            end
         end
         SETUP: begin
            next_val_d   = 1'b1;
            line_count_d = line_count_q + 16'd1;
            state_d      = STROBE;
         end
         STROBE: begin
            state_d = ACCUM;
            if (last_pend_q) begin
               done_d      = 1'b1;
               last_pend_d = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACCUM;
         acc_q        <= '0;
         have_digit_q <= 1'b0;
         par_q        <= '0;
         next_val_q   <= 1'b0;
         line_count_q <= '0;
         done_q       <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_char_q   <= 1'b0;
         last_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         have_digit_q <= have_digit_d;
         par_q        <= par_d;
         next_val_q   <= next_val_d;
         line_count_q <= line_count_d;
         done_q       <= done_d;
         err_ovf_q    <= err_ovf_d;
         err_char_q   <= err_char_d;
         last_pend_q  <= last_pend_d;
      end
   end

   assign par_input    = par_q;
   assign next_val     = next_val_q;
   assign line_count   = line_count_q;
   assign done         = done_q;
   assign err_overflow = err_ovf_q;
   assign err_char     = err_char_q;

endmodule
